// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews activation vectors onto the array west edge and sequences clear/stream/drain/done.
// Defining SKEW_FEEDER_PERF_EN builds the saturating bubble counter; otherwise bubble_count is tied to 0.
module systolic_skew_feeder #(
   parameter int DATA_BITS = 16,
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int MAC_LAT   = 2,
   parameter int K_BITS    = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      start,
   input  logic [K_BITS-1:0]         k_len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ROWS*DATA_BITS-1:0] in_data,
   output logic [ROWS*DATA_BITS-1:0] a_west,
   output logic [ROWS-1:0]           v_west,
   output logic                      clear_acc,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               bubble_count
);
   localparam int D  = (ROWS-1) + (COLS-1) + MAC_LAT;
   localparam int DW = $clog2(D+1);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [K_BITS-1:0] k_reg, beat_cnt;
   logic [DW-1:0]     drain_cnt;
   logic              accept, last_beat, drain_end;

   assign in_ready  = enable & (state == STREAM);
   assign accept    = in_ready & in_valid;
   assign last_beat = accept & (beat_cnt == k_reg - K_BITS'(1));
   assign drain_end = drain_cnt == DW'(D-1);
   assign clear_acc = state == CLEAR;
   assign busy      = state != IDLE;
   assign done      = state == DONE;

   always_comb begin
      state_nxt = state;
      if (enable)
         case (state)
            IDLE:    if (start && k_len != '0) state_nxt = CLEAR;
            CLEAR:   state_nxt = STREAM;
            STREAM:  if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         k_reg     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else if (enable) begin
         if (state == IDLE) k_reg <= k_len;
         beat_cnt  <= (state == CLEAR) ? '0 : beat_cnt + K_BITS'(accept);
         drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      end

   // Stage 0 is the common output register; lane r adds r more stages behind it.
   genvar r;
   generate
      for (r = 0; r < ROWS; r++) begin : g_lane
         logic [DATA_BITS-1:0] d [0:r];
         logic [r:0]           v;
         always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
               d <= '{default: '0};
               v <= '0;
            end else if (enable) begin
               d[0] <= accept ? in_data[r*DATA_BITS +: DATA_BITS] : '0;
               v[0] <= accept;
               for (int i = 1; i <= r; i++) begin
                  d[i] <= d[i-1];
                  v[i] <= v[i-1];
               end
            end
         assign a_west[r*DATA_BITS +: DATA_BITS] = d[r];
         assign v_west[r] = v[r];
      end
   endgenerate

`ifdef SKEW_FEEDER_PERF_EN
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         bubble_count <= '0;
      else if (enable)
         bubble_count <= (state == IDLE && state_nxt == CLEAR) ? '0 :
                         (state == STREAM && !accept && bubble_count != 16'hFFFF) ? bubble_count + 16'd1 :
                         bubble_count;
`else
   assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: table-driven, directed and randomized checks of the skew feeder
// against a pass-schedule model keyed by the enabled-edge index of each accepted beat.
module tb_systolic_skew_feeder;
   localparam int D = 8;
   localparam logic [63:0] Z  = 64'd0;
   localparam logic [63:0] BA = 64'h4000_3000_2000_1000;
   localparam logic [63:0] BB = 64'h2000_1800_1000_0800;
   localparam logic [63:0] BC = 64'hFFFF_0001_8000_7FFF;

   logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [7:0]  k_len = 8'd0;
   logic [63:0] in_data = 64'd0;
   logic        in_ready, clear_acc, busy, done;
   logic [63:0] a_west;
   logic [3:0]  v_west;
   logic [15:0] bubble_count;

   int passed = 0, total = 0, cyc = 0;

   logic [63:0] hist [int];
   int          m_n = 0, m_start_n = 0, m_last_n = 0, m_got = 0, m_k = 0;
   bit          m_act = 1'b0, m_rdy = 1'b0, rdy_s = 1'b0;
   logic [15:0] m_bub = 16'd0;

   typedef struct {
      int          st, kl, iv;
      logic [63:0] d;
      bit          rdy;
      logic [3:0]  v;
      logic [63:0] a;
      bit          clr, dn, bsy;
   } vec_t;
   vec_t tv [14];

   systolic_skew_feeder dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .a_west(a_west),
      .v_west(v_west), .clear_acc(clear_acc), .busy(busy), .done(done),
      .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [15:0] exp_bub();
`ifdef SKEW_FEEDER_PERF_EN
      return m_bub;
`else
      return 16'd0;
`endif
   endfunction

   task automatic step(input int en, input int st, input int kl, input int iv, input logic [63:0] d);
      logic [63:0] ea, t;
      logic [3:0]  ev;
      bit          was_act, acc;
      enable = 1'(en); start = 1'(st); k_len = 8'(kl); in_valid = 1'(iv); in_data = d;
      @(negedge clk);
      m_rdy = en != 0 && m_act && m_n > m_start_n && m_got < m_k;
      rdy_s = in_ready;
      check("in_ready", 64'(in_ready), 64'(m_rdy));
      @(posedge clk);
      cyc++;
      if (en != 0) begin
         was_act = m_act;
         acc = iv != 0 && m_rdy;
         m_n++;
         if (m_rdy && iv == 0 && m_bub != 16'hFFFF) m_bub++;
         if (acc) begin
            hist[m_n] = d;
            m_got++;
            if (m_got == m_k) m_last_n = m_n;
         end
         if (m_act && m_got == m_k && m_n == m_last_n + D + 1) m_act = 1'b0;
         if (!was_act && st != 0 && kl != 0) begin
            m_act = 1'b1; m_start_n = m_n; m_k = kl; m_got = 0; m_bub = 16'd0;
         end
      end
      #1;
      ea = '0; ev = '0;
      for (int r = 0; r < 4; r++)
         if (hist.exists(m_n - r)) begin
            t = hist[m_n - r];
            ev[r] = 1'b1;
            ea[r*16 +: 16] = t[r*16 +: 16];
         end
      check("a_west", a_west, ea);
      check("v_west", 64'(v_west), 64'(ev));
      check("clear_acc", 64'(clear_acc), 64'(m_act && m_n == m_start_n));
      check("busy", 64'(busy), 64'(m_act));
      check("done", 64'(done), 64'(m_act && m_got == m_k && m_n == m_last_n + D));
      check("bubble_count", 64'(bubble_count), 64'(exp_bub()));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_a_west"}, a_west, Z);
      check({tag, "_v_west"}, 64'(v_west), Z);
      check({tag, "_in_ready"}, 64'(in_ready), Z);
      check({tag, "_clear_acc"}, 64'(clear_acc), Z);
      check({tag, "_busy"}, 64'(busy), Z);
      check({tag, "_done"}, 64'(done), Z);
      check({tag, "_bubble"}, 64'(bubble_count), Z);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1 check_zero("rst");
      hist.delete();
      m_n = 0; m_act = 1'b0; m_got = 0; m_k = 0; m_bub = 16'd0; m_start_n = 0; m_last_n = 0;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic run_to_done(input string name, input int exp_len, input int c0);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         step(1, 0, 0, 0, Z);
         n++;
      end
      check(name, 64'(cyc - c0), 64'(exp_len));
      step(1, 0, 0, 0, Z);
      check({name, "_idle"}, 64'(busy), Z);
   endtask

   initial begin
      int c0;
      tv[0]  = '{1, 3, 0, Z,  1'b0, 4'b0000, Z, 1'b1, 1'b0, 1'b1};
      tv[1]  = '{0, 0, 1, BA, 1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b1};
      tv[2]  = '{0, 0, 1, BA, 1'b1, 4'b0001, 64'h0000_0000_0000_1000, 1'b0, 1'b0, 1'b1};
      tv[3]  = '{0, 0, 1, BB, 1'b1, 4'b0011, 64'h0000_0000_2000_0800, 1'b0, 1'b0, 1'b1};
      tv[4]  = '{0, 0, 1, BC, 1'b1, 4'b0111, 64'h0000_3000_1000_7FFF, 1'b0, 1'b0, 1'b1};
      tv[5]  = '{0, 0, 0, Z,  1'b0, 4'b1110, 64'h4000_1800_8000_0000, 1'b0, 1'b0, 1'b1};
      tv[6]  = '{0, 0, 0, Z,  1'b0, 4'b1100, 64'h2000_0001_0000_0000, 1'b0, 1'b0, 1'b1};
      tv[7]  = '{0, 0, 0, Z,  1'b0, 4'b1000, 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, 1'b1};
      tv[8]  = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b1};
      tv[9]  = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b1};
      tv[10] = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b1};
      tv[11] = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b1};
      tv[12] = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b1, 1'b1};
      tv[13] = '{0, 0, 0, Z,  1'b0, 4'b0000, Z, 1'b0, 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      #1 check_zero("init");
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(1, tv[i].st, tv[i].kl, tv[i].iv, tv[i].d);
         check($sformatf("tv%0d_ready", i), 64'(rdy_s), 64'(tv[i].rdy));
         check($sformatf("tv%0d_v", i), 64'(v_west), 64'(tv[i].v));
         check($sformatf("tv%0d_a", i), a_west, tv[i].a);
         check($sformatf("tv%0d_clr", i), 64'(clear_acc), 64'(tv[i].clr));
         check($sformatf("tv%0d_done", i), 64'(done), 64'(tv[i].dn));
         check($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].bsy));
      end

      step(1, 1, 3, 0, Z); c0 = cyc;
      step(1, 0, 0, 0, Z);
      step(1, 0, 0, 1, BA);
      step(1, 0, 0, 0, Z);  check("bubble_v0", 64'(v_west), 64'(4'b0010));
      step(1, 0, 0, 1, BB); check("bubble_v1", 64'(v_west), 64'(4'b0101));
      step(1, 0, 0, 1, BC); check("bubble_v2", 64'(v_west), 64'(4'b1011));
      run_to_done("bubble_len", 13, c0);
`ifdef SKEW_FEEDER_PERF_EN
      check("bubble_count_end", 64'(bubble_count), 64'd1);
`else
      check("bubble_count_end", 64'(bubble_count), 64'd0);
`endif

      step(1, 1, 3, 0, Z); c0 = cyc;
      step(1, 0, 0, 1, BA);
      step(1, 0, 0, 1, BA);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, BB);
         check("stall_ready", 64'(rdy_s), Z);
         check("stall_v", 64'(v_west), 64'(4'b0001));
         check("stall_a", a_west, 64'h1000);
      end
      step(1, 0, 0, 1, BB);
      step(1, 0, 0, 1, BC);
      run_to_done("stall_len", 15, c0);

      step(1, 1, 0, 0, Z);
      check("k0_busy", 64'(busy), Z);
      check("k0_clear", 64'(clear_acc), Z);
      step(1, 0, 0, 0, Z);
      step(1, 1, 2, 0, Z); c0 = cyc;
      step(1, 1, 7, 0, Z);  check("ign_clear", 64'(clear_acc), Z);
      step(1, 1, 5, 1, BA);
      step(1, 1, 5, 1, BB); check("ign_busy", 64'(busy), 64'd1);
      run_to_done("ign_len", 11, c0);

      step(1, 1, 2, 0, Z);
      step(1, 0, 0, 1, BA);
      step(1, 0, 0, 1, BA);
      step(1, 0, 0, 1, BB);
      repeat (3) step(1, 0, 0, 0, Z);
      do_reset();
      check("post_rst_busy", 64'(busy), Z);
      step(1, 1, 1, 0, Z); c0 = cyc;
      step(1, 0, 0, 1, BC);
      step(1, 0, 0, 1, BC);
      check("k1_v0", 64'(v_west), 64'(4'b0001));
      check("k1_a0", a_west, 64'h7FFF);
      step(1, 0, 0, 0, Z);
      check("k1_v1", 64'(v_west), 64'(4'b0010));
      check("k1_a1", a_west, 64'h0000_0000_8000_0000);
      run_to_done("k1_len", 10, c0);

      for (int i = 0; i < 400; i++)
         step(int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 9) < 7), {$urandom, $urandom});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
